logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RSTn  input  1  asynchronous, active-low reset.
REQ-004 Req0, Req1  input  1 each  request from requester 0 or 1.
REQ-005 Op0, Op1  input  2 each  operation code: 00 AND, 01 OR, 10 XOR, 11 NOR, all bitwise.
REQ-006 A0, B0, A1, B1  input  WIDTH each  operands of requester 0 and requester 1.
REQ-007 Gnt0, Gnt1  output  1 each  grant pulse; operands have been captured.
REQ-008 Done0, Done1  output  1 each  completion pulse; Result is valid.
REQ-009 Result  output  WIDTH  registered result of the last completed operation.
REQ-010 Result_Src  output  1  requester that owns Result.
REQ-011 Busy  output  1  high whenever the state is not IDLE.
REQ-012 Count  output  8  number of completed operations, modulo 256.

Function
REQ-013 The block SHALL contain one shared registered logic unit and a three-state FSM: IDLE, EXEC, RESP.
REQ-014 Cycle numbering: cycle c is the clock period that follows rising edge c.
REQ-015 In IDLE, when at least one Req is high at edge k, the block SHALL select one requester.
REQ-016 At edge k it SHALL register that requester's Op, A and B, and SHALL move to EXEC.
REQ-017 In IDLE with both Req low, the FSM SHALL remain in IDLE.
REQ-018 In EXEC (cycle k), the block SHALL assert Gnt of the selected requester for exactly one cycle.
REQ-019 In EXEC, the block SHALL compute f(Op, A, B) on the captured values; at edge k+1 it SHALL load Result, load Result_Src and move to RESP.
REQ-020 In RESP (cycle k+1), the block SHALL assert Done of the selected requester for exactly one cycle; at edge k+2 it SHALL increment Count and return to IDLE.
REQ-021 Latency: capture to Done is 1 cycle. Throughput is at most one operation per 3 cycles; the next capture occurs no earlier than edge k+3.
REQ-022 Result and Result_Src SHALL hold their values until the next RESP load.
REQ-023 Changes to Req, Op or operands after capture SHALL NOT affect the operation in flight.
REQ-024 Handshake: a requester SHALL hold Req, Op and operands stable until Gnt is seen, then deassert Req from cycle k+1.
REQ-025 If a requester keeps Req high through IDLE, this SHALL be treated as a new request.
REQ-026 Arbitration is round-robin using a 1-bit priority pointer.
REQ-027 When both Req are high in IDLE, the block SHALL select the requester named by the pointer.
REQ-028 When only one Req is high, the block SHALL select that requester regardless of the pointer.
REQ-029 At every capture, the pointer SHALL be set to the requester that was not selected.
REQ-030 Count SHALL wrap from 0xFF to 0x00 without any flag.
REQ-031 Gnt0 and Gnt1 SHALL never both be high; Done0 and Done1 SHALL never both be high.

Reset
REQ-032 While RSTn is low, the block SHALL force the following values, independent of CLK: state IDLE, pointer selecting requester 0, Gnt/Done/Busy/Result_Src = 0, Result = 0, Count = 0.
REQ-033 If reset is asserted during EXEC or RESP, the in-flight operation SHALL be discarded, no Done SHALL be issued, and Count SHALL remain 0.
REQ-034 After RSTn rises, the first capture SHALL occur no earlier than the first rising edge of CLK.

Verification
REQ-035 Reset: hold RSTn low for 3 cycles while Req0 = Req1 = 1 -> all outputs 0, no Gnt.
REQ-036 Single request: Req0 = 1, Op0 = 00, A0 = 0xF0, B0 = 0x3C, captured at edge k.
- Gnt0 high in cycle k.
- Done0 high in cycle k+1.
- Result = 0x30, Result_Src = 0, Count = 1.
REQ-037 Contention after reset: Req0 with OR 0x0F/0xF0 and Req1 with XOR 0xAA/0xFF, both held until their Gnt.
- Done0 in cycle k+1 with Result = 0xFF.
- Done1 in cycle k+4 with Result = 0x55, Result_Src = 1.
REQ-038 Round-robin: both Req continuously re-asserted, with NOR 0x00/0x0F for both -> grants alternate 0, 1, 0, 1, each Result = 0xF0.
REQ-039 Reset mid-operation: pulse RSTn low in EXEC cycle k -> no Done0 in cycle k+1, Busy = 0, Count = 0, Result = 0x00.
REQ-040 Wrap: 256 back-to-back completions -> Count = 0x00; the 257th completion -> Count = 0x01.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Two requesters share one registered bitwise logic unit. A round-robin
//   arbiter picks a requester in IDLE, captures its Op/A/B, and the FSM steps
//   IDLE -> EXEC -> RESP -> IDLE, so one operation completes every 3 cycles.
//
// Ports
//   CLK, RSTn          clock, asynchronous active-low reset
//   Req0/1             request from requester 0/1
//   Op0/1              00 AND, 01 OR, 10 XOR, 11 NOR
//   A0/B0, A1/B1       operands (WIDTH bits)
//   Gnt0/1             one-cycle pulse in EXEC: operands captured
//   Done0/1            one-cycle pulse in RESP: Result valid
//   Result             result of the last completed operation
//   Result_Src         requester that owns Result
//   Busy               high whenever the FSM is not IDLE
//   Count              completed operations, modulo 256
module logic_unit_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             Req0,
   input  logic             Req1,
   input  logic [1:0]       Op0,
   input  logic [1:0]       Op1,
   input  logic [WIDTH-1:0] A0,
   input  logic [WIDTH-1:0] B0,
   input  logic [WIDTH-1:0] A1,
   input  logic [WIDTH-1:0] B1,
   output logic             Gnt0,
   output logic             Gnt1,
   output logic             Done0,
   output logic             Done1,
   output logic [WIDTH-1:0] Result,
   output logic             Result_Src,
   output logic             Busy,
   output logic [7:0]       Count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q;
   logic             ptr_q;
   logic             src_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             gnt0_q, gnt1_q, done0_q, done1_q;
   logic [WIDTH-1:0] result_q;
   logic             result_src_q;
   logic             busy_q;
   logic [7:0]       count_q;

   logic             any_req;
   logic             sel_d;
   logic [1:0]       op_d;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_d;
   logic [WIDTH-1:0] result_d;

   // Pointer only breaks ties; a lone request wins regardless of it.
   always_comb begin
      any_req = Req0 | Req1;
      sel_d   = (Req0 & Req1) ? ptr_q : Req1;
      op_d    = sel_d ? Op1 : Op0;
      a_d     = sel_d ? A1  : A0;
      b_d     = sel_d ? B1  : B0;
   end

   always_comb begin
      result_d = '0;
      unique case (op_q)
         2'b00:   result_d = a_q & b_q;
         2'b01:   result_d = a_q | b_q;
         2'b10:   result_d = a_q ^ b_q;
         default: result_d = ~(a_q | b_q);
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         src_q        <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         result_q     <= '0;
         result_src_q <= 1'b0;
         busy_q       <= 1'b0;
         count_q      <= '0;
      end else begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  src_q   <= sel_d;
                  ptr_q   <= ~sel_d;
                  op_q    <= op_d;
                  a_q     <= a_d;
                  b_q     <= b_d;
                  gnt0_q  <= ~sel_d;
                  gnt1_q  <= sel_d;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               result_q     <= result_d;
               result_src_q <= src_q;
               done0_q      <= ~src_q;
               done1_q      <= src_q;
               state_q      <= RESP;
            end
            RESP: begin
               count_q <= count_q + 8'd1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Gnt0       = gnt0_q;
   assign Gnt1       = gnt1_q;
   assign Done0      = done0_q;
   assign Done1      = done1_q;
   assign Result     = result_q;
   assign Result_Src = result_src_q;
   assign Busy       = busy_q;
   assign Count      = count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_logic_unit_arbiter;

   logic       CLK = 1'b0;
   logic       RSTn;
   logic       Req0, Req1;
   logic [1:0] Op0, Op1;
   logic [7:0] A0, B0, A1, B1;
   logic       Gnt0, Gnt1, Done0, Done1;
   logic [7:0] Result;
   logic       Result_Src;
   logic       Busy;
   logic [7:0] Count;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 CLK = ~CLK;

   logic_unit_arbiter #(.WIDTH(8)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .Req0(Req0), .Req1(Req1),
      .Op0(Op0), .Op1(Op1),
      .A0(A0), .B0(B0), .A1(A1), .B1(B1),
      .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
      .Result(Result), .Result_Src(Result_Src),
      .Busy(Busy), .Count(Count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      RSTn = 1'b0;
      Req0 = 1'b1; Req1 = 1'b1;
      Op0 = 2'b00; Op1 = 2'b00;
      A0 = '0; B0 = '0; A1 = '0; B1 = '0;

      // Reset held 3 cycles with both requests high
      repeat (3) @(negedge CLK);
      chk("rst_gnt0",  Gnt0, 0);
      chk("rst_gnt1",  Gnt1, 0);
      chk("rst_done",  {Done0, Done1}, 0);
      chk("rst_busy",  Busy, 0);
      chk("rst_res",   Result, 0);
      chk("rst_src",   Result_Src, 0);
      chk("rst_count", Count, 0);
      Req0 = 1'b0; Req1 = 1'b0;
      RSTn = 1'b1;

      // Single request: AND F0/3C
      @(negedge CLK);
      Req0 = 1'b1; Op0 = 2'b00; A0 = 8'hF0; B0 = 8'h3C;
      @(negedge CLK);
      chk("s_gnt0", Gnt0, 1);
      chk("s_gnt1", Gnt1, 0);
      chk("s_busy", Busy, 1);
      Req0 = 1'b0; A0 = 8'h00;
      @(negedge CLK);
      chk("s_done0", Done0, 1);
      chk("s_gnt0b", Gnt0, 0);
      chk("s_res",   Result, 8'h30);
      chk("s_src",   Result_Src, 0);
      @(negedge CLK);
      chk("s_done0b", Done0, 0);
      chk("s_idle",   Busy, 0);
      chk("s_count",  Count, 1);

      // Contention after reset: pointer starts at requester 0
      RSTn = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1;
      Req0 = 1'b1; Op0 = 2'b01; A0 = 8'h0F; B0 = 8'hF0;
      Req1 = 1'b1; Op1 = 2'b10; A1 = 8'hAA; B1 = 8'hFF;
      @(negedge CLK);
      chk("c_gnt0", Gnt0, 1);
      chk("c_gnt1", Gnt1, 0);
      Req0 = 1'b0;
      @(negedge CLK);
      chk("c_done0", Done0, 1);
      chk("c_done1", Done1, 0);
      chk("c_res0",  Result, 8'hFF);
      @(negedge CLK);
      chk("c_wait_gnt1", Gnt1, 0);
      @(negedge CLK);
      chk("c_gnt1b", Gnt1, 1);
      chk("c_gnt0b", Gnt0, 0);
      Req1 = 1'b0;
      @(negedge CLK);
      chk("c_done1b", Done1, 1);
      chk("c_res1",   Result, 8'h55);
      chk("c_src1",   Result_Src, 1);
      @(negedge CLK);
      chk("c_count", Count, 2);

      // Round-robin with both requests held: NOR 00/0F -> F0
      Req0 = 1'b1; Op0 = 2'b11; A0 = 8'h00; B0 = 8'h0F;
      Req1 = 1'b1; Op1 = 2'b11; A1 = 8'h00; B1 = 8'h0F;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("rr_gnt0", Gnt0, (i % 2 == 0) ? 1 : 0);
         chk("rr_gnt1", Gnt1, (i % 2 == 0) ? 0 : 1);
         @(negedge CLK);
         chk("rr_done0", Done0, (i % 2 == 0) ? 1 : 0);
         chk("rr_done1", Done1, (i % 2 == 0) ? 0 : 1);
         chk("rr_res",   Result, 8'hF0);
         chk("rr_src",   Result_Src, (i % 2 == 0) ? 0 : 1);
         @(negedge CLK);
         chk("rr_idle", Busy, 0);
      end
      Req0 = 1'b0; Req1 = 1'b0;
      chk("rr_count", Count, 6);

      // Reset pulse during EXEC discards the operation
      @(negedge CLK);
      Req0 = 1'b1; Op0 = 2'b01; A0 = 8'h12; B0 = 8'h34;
      @(negedge CLK);
      chk("m_gnt0", Gnt0, 1);
      Req0 = 1'b0;
      RSTn = 1'b0;
      #1;
      chk("m_async_busy", Busy, 0);
      chk("m_async_gnt0", Gnt0, 0);
      #1;
      RSTn = 1'b1;
      @(negedge CLK);
      chk("m_done0", Done0, 0);
      chk("m_busy",  Busy, 0);
      chk("m_count", Count, 0);
      chk("m_res",   Result, 8'h00);

      // Wrap: 256 back-to-back completions
      Req0 = 1'b1; Op0 = 2'b10; A0 = 8'h5A; B0 = 8'h0F;
      n = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge CLK);
         if (Done0) n++;
         if (n == 256) break;
      end
      Req0 = 1'b0;
      chk("w_completions", n, 256);
      chk("w_res", Result, 8'h55);
      @(negedge CLK);
      chk("w_count0", Count, 8'h00);
      chk("w_busy",   Busy, 0);
      Req0 = 1'b1;
      @(negedge CLK);
      chk("w_gnt0", Gnt0, 1);
      Req0 = 1'b0;
      @(negedge CLK);
      chk("w_done0", Done0, 1);
      @(negedge CLK);
      chk("w_count1", Count, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
